// File: rtl/fluxo_dados_jogo.sv
// Datapath for the sequence-memory game: sequence memory, counters,
// move and mode registers, response and LED timers, RGB LED drive.
module fluxo_dados_jogo #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int LED_CYCLES     = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       chave_timeout,
  input  logic       chave_dificil,
  input  logic       zera_endereco,
  input  logic       conta_endereco,
  input  logic       zera_limite,
  input  logic       conta_limite,
  input  logic       zeraR,
  input  logic       registrarR,
  input  logic       zera_modo,
  input  logic       registra_modo,
  input  logic       zera_s_timeout,
  input  logic       enable_timeout,
  input  logic       zera_s_led,
  input  logic       enable_led,
  input  logic       conf_leds,
  input  logic       registra_jogada,
  output logic       jogada,
  output logic       igual,
  output logic       enderecoIgualLimite,
  output logic       fim_sequencia,
  output logic       fim_jogo,
  output logic       timeout,
  output logic       timeout_led,
  output logic       timeout_habilitado,
  output logic [3:0] leds,
  output logic [3:0] db_endereco,
  output logic [3:0] db_limite,
  output logic [3:0] db_jogada,
  output logic [3:0] db_memoria
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LED_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LED_CYCLES - 1);

  logic [3:0]    endereco_q, endereco_d;
  logic [3:0]    limite_q, limite_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    ultima_q, ultima_d;
  logic          any_prev_q, any_prev_d;
  logic [1:0]    modo_q, modo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] tled_q, tled_d;
  logic [3:0]    leds_q, leds_d;
  logic [3:0]    mem_q [16];
  logic [3:0]    mem_d [16];
  logic [3:0]    mem_rd;

  assign mem_rd = mem_q[endereco_q];
  assign jogada = (|botoes) & ~any_prev_q;

  always_comb begin
    endereco_d = endereco_q;
    if (zera_endereco)       endereco_d = 4'd0;
    else if (conta_endereco) endereco_d = endereco_q + 4'd1;

    limite_d = limite_q;
    if (zera_limite)       limite_d = 4'd0;
    else if (conta_limite) limite_d = limite_q + 4'd1;

    modo_d = modo_q;
    if (zera_modo)          modo_d = 2'b00;
    else if (registra_modo) modo_d = {chave_timeout, chave_dificil};

    any_prev_d = |botoes;
    ultima_d   = jogada ? botoes : ultima_q;

    // R loads the captured press, so an early release is harmless
    r_d = r_q;
    if (zeraR)           r_d = 4'd0;
    else if (registrarR) r_d = ultima_q;

    mem_d = mem_q;
    if (registra_jogada && jogada) mem_d[endereco_q] = botoes;

    tmo_d = tmo_q;
    if (zera_s_timeout) tmo_d = '0;
    else if (enable_timeout && tmo_q != T_MAX) tmo_d = tmo_q + TW'(1);

    tled_d = tled_q;
    if (zera_s_led) tled_d = '0;
    else if (enable_led && tled_q != L_MAX) tled_d = tled_q + LW'(1);

    leds_d = conf_leds ? mem_rd : 4'b0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco_q <= 4'd0;
      limite_q   <= 4'd0;
      r_q        <= 4'd0;
      ultima_q   <= 4'd0;
      any_prev_q <= 1'b0;
      modo_q     <= 2'b00;
      tmo_q      <= '0;
      tled_q     <= '0;
      leds_q     <= 4'd0;
      for (int i = 0; i < 16; i++)
        mem_q[i] <= 4'b0001 << (i % 4);
    end else begin
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      r_q        <= r_d;
      ultima_q   <= ultima_d;
      any_prev_q <= any_prev_d;
      modo_q     <= modo_d;
      tmo_q      <= tmo_d;
      tled_q     <= tled_d;
      leds_q     <= leds_d;
      mem_q      <= mem_d;
    end
  end

  assign igual               = (r_q == mem_rd);
  assign enderecoIgualLimite = (endereco_q == limite_q);
  assign fim_sequencia       = (endereco_q == limite_q);
  assign fim_jogo            = (limite_q == (modo_q[0] ? 4'd15 : 4'd7));
  assign timeout             = (tmo_q == T_MAX);
  assign timeout_led         = (tled_q == L_MAX);
  assign timeout_habilitado  = modo_q[1];
  assign leds                = leds_q;
  assign db_endereco         = endereco_q;
  assign db_limite           = limite_q;
  assign db_jogada           = r_q;
  assign db_memoria          = mem_rd;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed self-checking bench for fluxo_dados_jogo.
module tb_fluxo_dados_jogo;

  logic clock = 1'b0;
  logic reset;
  logic [3:0] botoes;
  logic chave_timeout, chave_dificil;
  logic zera_endereco, conta_endereco;
  logic zera_limite, conta_limite;
  logic zeraR, registrarR;
  logic zera_modo, registra_modo;
  logic zera_s_timeout, enable_timeout;
  logic zera_s_led, enable_led;
  logic conf_leds, registra_jogada;
  logic jogada, igual, enderecoIgualLimite, fim_sequencia, fim_jogo;
  logic timeout, timeout_led, timeout_habilitado;
  logic [3:0] leds, db_endereco, db_limite, db_jogada, db_memoria;

  int n_chk = 0;
  int n_err = 0;
  int pulses;

  always #5 clock = ~clock;

  fluxo_dados_jogo #(.TIMEOUT_CYCLES(10), .LED_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .chave_timeout(chave_timeout), .chave_dificil(chave_dificil),
    .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
    .zera_limite(zera_limite), .conta_limite(conta_limite),
    .zeraR(zeraR), .registrarR(registrarR),
    .zera_modo(zera_modo), .registra_modo(registra_modo),
    .zera_s_timeout(zera_s_timeout), .enable_timeout(enable_timeout),
    .zera_s_led(zera_s_led), .enable_led(enable_led),
    .conf_leds(conf_leds), .registra_jogada(registra_jogada),
    .jogada(jogada), .igual(igual),
    .enderecoIgualLimite(enderecoIgualLimite),
    .fim_sequencia(fim_sequencia), .fim_jogo(fim_jogo),
    .timeout(timeout), .timeout_led(timeout_led),
    .timeout_habilitado(timeout_habilitado), .leds(leds),
    .db_endereco(db_endereco), .db_limite(db_limite),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic pulse_end(input int n);
    conta_endereco = 1'b1;
    cyc(n);
    conta_endereco = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    botoes = 4'd0;
    chave_timeout = 0; chave_dificil = 0;
    zera_endereco = 0; conta_endereco = 0;
    zera_limite = 0; conta_limite = 0;
    zeraR = 0; registrarR = 0;
    zera_modo = 0; registra_modo = 0;
    zera_s_timeout = 0; enable_timeout = 0;
    zera_s_led = 0; enable_led = 0;
    conf_leds = 0; registra_jogada = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_end", db_endereco, 0);
    chk("rst_lim", db_limite, 0);
    chk("rst_R", db_jogada, 0);
    chk("rst_leds", leds, 0);
    chk("rst_jog", jogada, 0);
    chk("rst_mem0", db_memoria, 1);
    chk("rst_igual", igual, 0);
    chk("rst_fimseq", fim_sequencia, 1);
    chk("rst_eil", enderecoIgualLimite, 1);
    chk("rst_fimjogo", fim_jogo, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_tled", timeout_led, 0);
    chk("rst_thab", timeout_habilitado, 0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mem%0d", i), db_memoria, 16'(4'b0001 << (i % 4)));
      pulse_end(1);
    end
    chk("end_wrap", db_endereco, 0);

    chave_timeout = 1; chave_dificil = 0; registra_modo = 1;
    cyc(); registra_modo = 0;
    chk("thab_on", timeout_habilitado, 1);
    conta_limite = 1; cyc(6); conta_limite = 0;
    chk("fim_l6", fim_jogo, 0);
    conta_limite = 1; cyc(); conta_limite = 0;
    chk("fim_l7", fim_jogo, 1);
    chk("eil_07", enderecoIgualLimite, 0);
    chave_dificil = 1; registra_modo = 1;
    cyc(); registra_modo = 0;
    chk("fimd_l7", fim_jogo, 0);
    conta_limite = 1; cyc(7); conta_limite = 0;
    chk("fimd_l14", fim_jogo, 0);
    conta_limite = 1; cyc(); conta_limite = 0;
    chk("lim15", db_limite, 15);
    chk("fimd_l15", fim_jogo, 1);
    zera_modo = 1; registra_modo = 1;
    cyc(); zera_modo = 0; registra_modo = 0;
    chk("modo_clr", timeout_habilitado, 0);
    chk("fim_clr", fim_jogo, 0);
    zera_limite = 1; conta_limite = 1;
    cyc(); zera_limite = 0; conta_limite = 0;
    chk("lim_clrwin", db_limite, 0);

    pulses = 0;
    botoes = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (jogada) pulses++;
      cyc();
    end
    botoes = 4'b0000;
    cyc(2);
    chk("one_pulse", 16'(pulses), 1);
    registrarR = 1; cyc(); registrarR = 0;
    chk("R_load", db_jogada, 4'b0100);
    chk("igual_a0", igual, 0);
    pulse_end(2);
    chk("igual_a2", igual, 1);

    botoes = 4'b0001; cyc();
    botoes = 4'b0011; #1;
    chk("no_2nd", jogada, 0);
    cyc(); botoes = 4'b0000; cyc();

    pulse_end(3);
    registra_jogada = 1;
    cyc(2);
    chk("no_early_wr", db_memoria, 4'b0010);
    botoes = 4'b1000; #1;
    chk("jog_pulse", jogada, 1);
    chk("wr_pre", db_memoria, 4'b0010);
    cyc();
    chk("wr_post", db_memoria, 4'b1000);
    botoes = 4'b0000; registra_jogada = 0; cyc();

    pulse_end(1);
    chk("igual_a6", igual, 1);
    registra_jogada = 1; botoes = 4'b1000; #1;
    chk("igual_old", igual, 1);
    cyc();
    registra_jogada = 0; botoes = 4'b0000;
    chk("igual_new", igual, 0);
    chk("mem6_new", db_memoria, 4'b1000);
    zeraR = 1; registrarR = 1;
    cyc(); zeraR = 0; registrarR = 0;
    chk("R_clrwin", db_jogada, 0);

    enable_timeout = 1;
    cyc(8);
    chk("tmo_8", timeout, 0);
    cyc();
    chk("tmo_9", timeout, 1);
    cyc(3);
    chk("tmo_sat", timeout, 1);
    zera_s_timeout = 1; cyc(); zera_s_timeout = 0;
    chk("tmo_clr", timeout, 0);
    enable_timeout = 0;

    enable_led = 1; cyc(2); enable_led = 0;
    cyc(5);
    chk("tled_hold", timeout_led, 0);
    enable_led = 1; cyc(); enable_led = 0;
    chk("tled_3", timeout_led, 1);

    zera_endereco = 1; cyc(); zera_endereco = 0;
    pulse_end(3);
    conf_leds = 1; cyc(); conf_leds = 0;
    chk("leds_on", leds, 4'b1000);
    cyc();
    chk("leds_off", leds, 0);

    conta_limite = 1; cyc(2); conta_limite = 0;
    chave_timeout = 1; registra_modo = 1; cyc(); registra_modo = 0;
    conf_leds = 1; enable_timeout = 1; cyc(3);
    #2 reset = 1'b1;
    #1;
    chk("mr_end", db_endereco, 0);
    chk("mr_lim", db_limite, 0);
    chk("mr_leds", leds, 0);
    chk("mr_thab", timeout_habilitado, 0);
    chk("mr_mem0", db_memoria, 1);
    conf_leds = 0; enable_timeout = 0;
    @(negedge clock);
    reset = 1'b0;
    cyc();
    pulse_end(5);
    chk("mr_mem5", db_memoria, 4'b0010);
    pulse_end(1);
    chk("mr_mem6", db_memoria, 4'b0100);
    chk("mr_tmo", timeout, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
